// File: rtl/ntt_stream_ctrl.sv
// AXIS-to-NTT-core sequencer: load 4*N_PER_PROC words, start, await finish, read back through a credit-checked output FIFO.
// Load path is 1 cycle; reads stall when in-flight + buffered words would overflow the FIFO; tlast framing check under NTT_STREAM_TLAST_CHECK_EN.
module ntt_stream_ctrl #(
    parameter int N_PER_PROC = 256,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [31:0] core_din,
    output logic [1:0]  core_din_num,
    output logic        core_din_valid,
    output logic        core_start,
    input  logic        core_finish,
    output logic [1:0]  core_rd_num,
    output logic        core_rd_valid,
    input  logic [31:0] core_dout,
    input  logic        core_dout_valid,
    output logic        core_rst_b,
    output logic        busy,
    output logic        err
);
    localparam int TOTAL = 4 * N_PER_PROC;
    localparam int CW    = $clog2(TOTAL) + 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int FW    = AW + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);
    localparam logic [CW-1:0] TOTAL_C  = CW'(TOTAL);
    localparam logic [FW-1:0] DEPTH_C  = FW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, UNLOAD, DRAIN, CLR} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   ld_cnt, rd_cnt, out_cnt;
    logic [FW-1:0]   outstanding, fifo_count;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [31:0]     fifo_mem [FIFO_DEPTH];
    logic            ld_hs, rd_req, credit_ok, push, pop, clr_pulse;

    assign s_axis_tready = (state == LOAD);
    assign ld_hs         = (state == LOAD) && s_axis_tvalid;
    // Every word requested but not yet popped already owns a FIFO slot.
    assign credit_ok     = ({1'b0, outstanding} + {1'b0, fifo_count}) < {1'b0, DEPTH_C};

    assign pop  = m_axis_tready && (fifo_count != '0);
    assign push = core_dout_valid && ((fifo_count != DEPTH_C) || pop);

    assign m_axis_tvalid = (fifo_count != '0);
    assign m_axis_tdata  = m_axis_tvalid ? fifo_mem[rd_ptr] : 32'd0;
    assign m_axis_tlast  = m_axis_tvalid && (out_cnt == LAST_IDX);

    assign core_rd_valid = rd_req;
    assign core_rd_num   = rd_cnt[CW-2 -: 2];
    assign core_rst_b    = rst_b & ~clr_pulse;
    assign busy          = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        core_start = 1'b0;
        rd_req     = 1'b0;
        clr_pulse  = 1'b0;
        case (state)
            IDLE:   state_nxt = LOAD;
            LOAD:   if (ld_hs && (ld_cnt == LAST_IDX)) state_nxt = START;
            START: begin
                core_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT:   if (core_finish) state_nxt = UNLOAD;
            UNLOAD: begin
                rd_req = credit_ok;
                if (credit_ok && (rd_cnt == LAST_IDX)) state_nxt = DRAIN;
            end
            DRAIN:  if (out_cnt == TOTAL_C) state_nxt = CLR;
            CLR: begin
                clr_pulse = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state          <= IDLE;
            ld_cnt         <= '0;
            rd_cnt         <= '0;
            out_cnt        <= '0;
            outstanding    <= '0;
            fifo_count     <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            core_din       <= 32'd0;
            core_din_num   <= 2'd0;
            core_din_valid <= 1'b0;
        end else begin
            state          <= state_nxt;
            core_din_valid <= ld_hs;
            if (ld_hs) begin
                core_din     <= s_axis_tdata;
                core_din_num <= ld_cnt[CW-2 -: 2];
            end
            if (state == CLR) begin
                ld_cnt  <= '0;
                rd_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (ld_hs)  ld_cnt  <= ld_cnt + CW'(1);
                if (rd_req) rd_cnt  <= rd_cnt + CW'(1);
                if (pop)    out_cnt <= out_cnt + CW'(1);
            end
            case ({rd_req, core_dout_valid})
                2'b10:   outstanding <= outstanding + FW'(1);
                2'b01:   outstanding <= outstanding - FW'(1);
                default: outstanding <= outstanding;
            endcase
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FW'(1);
                2'b01:   fifo_count <= fifo_count - FW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= core_dout;
    end

`ifdef NTT_STREAM_TLAST_CHECK_EN
    // Framing is advisory: loading still advances purely by count.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            err <= 1'b0;
        end else if (ld_hs && (s_axis_tlast != (ld_cnt == LAST_IDX))) begin
            err <= 1'b1;
        end
    end
`else
    logic tlast_unused;
    assign tlast_unused = s_axis_tlast;
    assign err          = 1'b0;
`endif

endmodule
